// File: rtl/rx_block_loader_if.sv
// Byte-in / block-out bundle for the receiver block loader.
// slave is the loader side, master is the byte source plus block consumer.
interface rx_block_loader_if #(
  parameter int BLOCK_BYTES = 64
);
  logic                     rx_data_ready;
  logic [7:0]               rx_data;
  logic                     rx_endofpacket;
  logic                     blk_valid;
  logic [8*BLOCK_BYTES-1:0] blk_data;
  logic                     blk_first;
  logic                     blk_ready;
  logic                     busy;
  logic                     err_abort;
  logic                     err_overrun;

  modport slave (
    input  rx_data_ready, rx_data, rx_endofpacket, blk_ready,
    output blk_valid, blk_data, blk_first, busy,
    output err_abort, err_overrun
  );

  modport master (
    output rx_data_ready, rx_data, rx_endofpacket, blk_ready,
    input  blk_valid, blk_data, blk_first, busy,
    input  err_abort, err_overrun
  );
endinterface

// File: rtl/rx_block_loader.sv
// Packs received bytes little-endian into fixed-size blocks and offers
// each full block on a valid/ready handshake; packet gaps frame messages.
module rx_block_loader #(
  parameter int BLOCK_BYTES = 64
) (
  input logic              clk,
  input logic              rst,
  rx_block_loader_if.slave bus
);
  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam int DW = 8 * BLOCK_BYTES;

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            first_pend_q, first_pend_d;
  logic            first_q, first_d;
  logic [DW-1:0]   data_q, data_d;
  logic            abort_q, abort_d;
  logic            overrun_q, overrun_d;
  logic            wr_en;
  logic [CW-1:0]   wr_idx;

  // Next-state: byte placement, block completion, handshake and errors.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    first_pend_d = first_pend_q;
    first_d      = first_q;
    data_d       = data_q;
    abort_d      = 1'b0;
    overrun_d    = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = cnt_q;
    unique case (state_q)
      COLLECT: begin
        if (bus.rx_endofpacket) begin
          abort_d      = (cnt_q != '0);
          cnt_d        = '0;
          first_pend_d = 1'b1;
        end else if (bus.rx_data_ready) begin
          wr_en = 1'b1;
          if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
            state_d      = HOLD;
            cnt_d        = '0;
            first_d      = first_pend_q;
            first_pend_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.rx_endofpacket) begin
          first_pend_d = 1'b1;
        end
        if (bus.blk_ready) begin
          state_d = COLLECT;
          first_d = 1'b0;
          if (bus.rx_data_ready && !bus.rx_endofpacket) begin
            wr_en  = 1'b1;
            wr_idx = '0;
            cnt_d  = CW'(1);
          end
        end else if (bus.rx_data_ready && !bus.rx_endofpacket) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (wr_en && wr_idx == CW'(i)) begin
        data_d[8*i +: 8] = bus.rx_data;
      end
    end
  end

  // State and output registers; reset drops any pending block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      cnt_q        <= '0;
      first_pend_q <= 1'b1;
      first_q      <= 1'b0;
      data_q       <= '0;
      abort_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      first_pend_q <= first_pend_d;
      first_q      <= first_d;
      data_q       <= data_d;
      abort_q      <= abort_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.blk_valid   = (state_q == HOLD);
  assign bus.blk_first   = first_q;
  assign bus.blk_data    = data_q;
  assign bus.busy        = (state_q == COLLECT) && (cnt_q != '0);
  assign bus.err_abort   = abort_q;
  assign bus.err_overrun = overrun_q;
endmodule

// File: tb/tb_rx_block_loader.sv
// Scoreboard bench for rx_block_loader: directed byte streams push
// expected blocks, a negedge monitor pops and compares on each transfer.
module tb_rx_block_loader;
  localparam int BB = 64;
  localparam int DW = 8 * BB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rx_block_loader_if #(.BLOCK_BYTES(BB)) bus ();

  rx_block_loader #(.BLOCK_BYTES(BB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int aborts = 0;
  int overruns = 0;
  int xfers = 0;

  logic [DW-1:0] exp_q[$];
  bit            expf_q[$];
  logic [DW-1:0] prev_data;
  bit            prev_hold = 0;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_w(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_block(logic [7:0] base);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < BB; i++) v[8*i +: 8] = base + 8'(i);
    return v;
  endfunction

  task automatic push(logic [DW-1:0] d, bit f);
    exp_q.push_back(d);
    expf_q.push_back(f);
  endtask

  task automatic cyc(bit rdy, logic [7:0] d, bit eop);
    bus.rx_data_ready  = rdy;
    bus.rx_data        = d;
    bus.rx_endofpacket = eop;
    @(posedge clk);
    #1;
    bus.rx_data_ready  = 1'b0;
    bus.rx_endofpacket = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_bytes(logic [7:0] base, int n);
    for (int i = 0; i < n; i++) cyc(1'b1, base + 8'(i), 1'b0);
  endtask

  task automatic chk_zero(string nm);
    chk_w({nm, "_valid"}, 32'(bus.blk_valid), 32'd0);
    chk_w({nm, "_first"}, 32'(bus.blk_first), 32'd0);
    chk_w({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk_w({nm, "_abort"}, 32'(bus.err_abort), 32'd0);
    chk_w({nm, "_overrun"}, 32'(bus.err_overrun), 32'd0);
    chk({nm, "_data"}, bus.blk_data, '0);
  endtask

  // Monitor: error pulse counting, hold stability, block scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 0;
    end else begin
      if (bus.err_abort) aborts++;
      if (bus.err_overrun) overruns++;
      if (prev_hold) begin
        chk_w("hold_valid", 32'(bus.blk_valid), 32'd1);
        chk("hold_stable", bus.blk_data, prev_data);
      end
      if (bus.blk_valid && bus.blk_ready) begin
        prev_hold = 0;
        xfers++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_block: got %h", bus.blk_data);
        end else begin
          chk("blk_data", bus.blk_data, exp_q.pop_front());
          chk_w("blk_first", 32'(bus.blk_first), 32'(expf_q.pop_front()));
        end
      end else if (bus.blk_valid) begin
        prev_hold = 1;
        prev_data = bus.blk_data;
      end else begin
        prev_hold = 0;
      end
    end
  end

  initial begin
    int a0;
    int o0;
    int x0;
    logic [DW-1:0] e;
    bus.rx_data_ready  = 1'b0;
    bus.rx_data        = 8'h00;
    bus.rx_endofpacket = 1'b0;
    bus.blk_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // 1) single block, latency and word placement
    push(mk_block(8'h00), 1'b1);
    send_bytes(8'h00, BB);
    chk_w("t1_valid", 32'(bus.blk_valid), 32'd1);
    chk_w("t1_first", 32'(bus.blk_first), 32'd1);
    chk_w("t1_w0", bus.blk_data[31:0], 32'h03020100);
    chk_w("t1_w15", bus.blk_data[511:480], 32'h3F3E3D3C);
    idle(1);
    chk_w("t1_valid_drop", 32'(bus.blk_valid), 32'd0);

    // 2) back-to-back blocks, then a new packet
    cyc(1'b0, 8'h00, 1'b1);
    push(mk_block(8'h40), 1'b1);
    push(mk_block(8'h80), 1'b0);
    send_bytes(8'h40, 2 * BB);
    cyc(1'b0, 8'h00, 1'b1);
    push(mk_block(8'h10), 1'b1);
    send_bytes(8'h10, BB);
    idle(2);

    // 3) partial block aborted by end of packet
    cyc(1'b0, 8'h00, 1'b1);
    a0 = aborts;
    x0 = xfers;
    send_bytes(8'h55, 10);
    chk_w("t3_busy", 32'(bus.busy), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk_w("t3_abort", 32'(bus.err_abort), 32'd1);
    chk_w("t3_busy0", 32'(bus.busy), 32'd0);
    idle(3);
    chk_w("t3_abort_cnt", 32'(aborts - a0), 32'd1);
    chk_w("t3_no_blk", 32'(xfers - x0), 32'd0);
    push(mk_block(8'h20), 1'b1);
    send_bytes(8'h20, BB);
    idle(2);

    // 4) overrun while holding, transfer with simultaneous byte
    cyc(1'b0, 8'h00, 1'b1);
    bus.blk_ready = 1'b0;
    e = mk_block(8'h30);
    push(e, 1'b1);
    send_bytes(8'h30, BB);
    idle(1);
    chk_w("t4_hold", 32'(bus.blk_valid), 32'd1);
    o0 = overruns;
    send_bytes(8'hE0, 3);
    idle(1);
    chk_w("t4_overruns", 32'(overruns - o0), 32'd3);
    chk("t4_data_kept", bus.blk_data, e);
    e = mk_block(8'h00);
    e[7:0] = 8'hAA;
    push(e, 1'b0);
    bus.blk_ready = 1'b1;
    cyc(1'b1, 8'hAA, 1'b0);
    chk_w("t4_valid0", 32'(bus.blk_valid), 32'd0);
    chk_w("t4_busy1", 32'(bus.busy), 32'd1);
    send_bytes(8'h01, BB - 1);
    idle(2);

    // 5) end of packet together with a byte
    cyc(1'b0, 8'h00, 1'b1);
    send_bytes(8'h90, 5);
    a0 = aborts;
    cyc(1'b1, 8'h99, 1'b1);
    chk_w("t5_abort", 32'(bus.err_abort), 32'd1);
    chk_w("t5_busy0", 32'(bus.busy), 32'd0);
    idle(2);
    chk_w("t5_abort_cnt", 32'(aborts - a0), 32'd1);
    a0 = aborts;
    cyc(1'b1, 8'h77, 1'b1);
    idle(2);
    chk_w("t5_no_abort", 32'(aborts - a0), 32'd0);
    chk_w("t5_dropped", 32'(bus.busy), 32'd0);
    push(mk_block(8'h60), 1'b1);
    send_bytes(8'h60, BB);
    idle(2);

    // 6) reset mid-block and during hold
    send_bytes(8'hC0, 30);
    chk_w("t6_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_zero("t6_rst_mid");
    bus.blk_ready = 1'b0;
    send_bytes(8'hD0, BB);
    idle(1);
    chk_w("t6_hold", 32'(bus.blk_valid), 32'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_zero("t6_rst_hold");
    bus.blk_ready = 1'b1;
    push(mk_block(8'h70), 1'b1);
    send_bytes(8'h70, BB);
    idle(2);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
    chk_w("drain", 32'(exp_q.size()), 32'd0);
    chk_w("xfer_total", 32'(xfers), 32'd9);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
